turbo_encoder_core: RTL and testbench

TURBO_ENCODER_CORE -- requirements
Module: turbo_encoder_core

---
 rtl/turbo_pkg.sv | 24 ++
 rtl/rsc_encoder.sv | 39 +++
 rtl/turbo_encoder_core.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_turbo_encoder_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared constants, state type and tap helper for the turbo encoder core
package turbo_pkg;

  localparam int K_W_DEFAULT = 13;
  localparam int TAIL_LEN    = 3;

  // Polynomial taps, bit i holds the coefficient of D^i.
  localparam logic [3:0] G0 = 4'b1101;  // feedback 1 + D^2 + D^3
  localparam logic [3:0] G1 = 4'b1011;  // parity   1 + D   + D^3

  typedef enum logic [2:0] {
    IDLE,
    ENC,
    TAIL1,
    TAIL2,
    DONE
  } enc_state_t;

  // XOR of the delay-line taps selected by a polynomial (D^1..D^3 terms only).
  function automatic logic tap_xor(input logic [3:0] g, input logic [3:1] s);
    return ^(g[3:1] & s);
  endfunction

endpackage

// File: rtl/rsc_encoder.sv
// rtl/rsc_encoder.sv - one 8-state recursive systematic convolutional constituent encoder
module rsc_encoder
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic aclr_n,
  input  logic clr,
  input  logic step,
  input  logic term,
  input  logic c_in,
  output logic c,
  output logic z
);

  // s[1] is the newest delay element, s[3] the oldest.
  logic [3:1] s;
  logic       fb;
  logic       a;

  // Feedback, effective input (feedback itself while terminating, so a = 0) and parity
  always_comb begin
    fb = tap_xor(G0, s);
    c  = term ? fb : c_in;
    a  = c ^ fb;
    z  = (G1[0] & a) ^ tap_xor(G1, s);
  end

  // Delay line: clear takes priority over a step
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      s <= '0;
    end else if (clr) begin
      s <= '0;
    end else if (step) begin
      s <= {s[2:1], a};
    end
  end

endmodule

// File: rtl/turbo_encoder_core.sv
// rtl/turbo_encoder_core.sv - rate-1/3 turbo encoder with systematic FIFO and trellis termination
module turbo_encoder_core
  import turbo_pkg::*;
#(
  parameter int K_W        = K_W_DEFAULT,
  parameter int FIFO_DEPTH = 512,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               aclr_n,
  input  logic               start,
  input  logic [K_W-1:0]     blk_k,
  input  logic               sys_valid,
  input  logic               sys_bit,
  output logic               sys_ready,
  input  logic               int_valid,
  input  logic               int_bit,
  output logic               read_request,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               xk,
  output logic               zk1,
  output logic               zk2,
  output logic               tail,
  output logic               busy,
  output logic               done,
  output logic               fifo_ovf,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam logic [1:0] TAIL_LAST = 2'(TAIL_LEN - 1);
  localparam logic [1:0] TAIL_WAIT = 2'(TAIL_LEN);

  // Systematic FIFO
  logic               fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level_q;
  logic               ovf_q;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_dout;

  // Control state
  enc_state_t         state;
  enc_state_t         state_n;
  logic [K_W-1:0]     k_q;
  logic [K_W-1:0]     bit_cnt;
  logic [1:0]         tail_cnt;
  logic               cnt_last;
  logic               adv;

  // Output beat register
  logic               ov_q;
  logic               xk_q;
  logic               zk1_q;
  logic               zk2_q;
  logic               tail_q;

  // Decoded controls
  logic               fire;
  logic               ld_out;
  logic               nx_xk;
  logic               nx_zk1;
  logic               nx_zk2;
  logic               nx_tail;
  logic               k_ld;
  logic               rsc_clr;
  logic               rsc1_step;
  logic               rsc2_step;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               tcnt_clr;
  logic               tcnt_inc;

  // Constituent encoder hookups
  logic               rsc1_term;
  logic               rsc2_term;
  logic               rsc1_c;
  logic               rsc1_z;
  logic               rsc2_c;
  logic               rsc2_z;

  // Full is judged on the registered level alone, so a pop never frees a slot in the same cycle.
  assign sys_ready  = (level_q != (FIFO_AW + 1)'(FIFO_DEPTH));
  assign push       = sys_valid && sys_ready;
  assign pop        = fire;
  assign fifo_empty = (level_q == '0);
  assign fifo_dout  = fifo_mem[rd_ptr];

  assign adv        = !ov_q || out_ready;
  assign cnt_last   = ((bit_cnt + K_W'(1)) == k_q);

  assign rsc1_term  = (state == TAIL1);
  assign rsc2_term  = (state == TAIL2);

  assign read_request = fire;
  assign out_valid    = ov_q;
  assign xk           = xk_q;
  assign zk1          = zk1_q;
  assign zk2          = zk2_q;
  assign tail         = tail_q;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign fifo_ovf     = ovf_q;
  assign fifo_level   = level_q;

  rsc_encoder u_rsc1 (
    .clk    (clk),
    .aclr_n (aclr_n),
    .clr    (rsc_clr),
    .step   (rsc1_step),
    .term   (rsc1_term),
    .c_in   (fifo_dout),
    .c      (rsc1_c),
    .z      (rsc1_z)
  );

  rsc_encoder u_rsc2 (
    .clk    (clk),
    .aclr_n (aclr_n),
    .clr    (rsc_clr),
    .step   (rsc2_step),
    .term   (rsc2_term),
    .c_in   (int_bit),
    .c      (rsc2_c),
    .z      (rsc2_z)
  );

  // FIFO storage: data only, no reset needed since pointers gate every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sys_bit;
    end
  end

  // FIFO pointers, fill level and sticky overflow flag
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + (FIFO_AW + 1)'(1);
      end else if (pop && !push) begin
        level_q <= level_q - (FIFO_AW + 1)'(1);
      end
      if (sys_valid && !sys_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus per-cycle datapath controls
  always_comb begin
    state_n   = state;
    fire      = 1'b0;
    ld_out    = 1'b0;
    nx_xk     = 1'b0;
    nx_zk1    = 1'b0;
    nx_zk2    = 1'b0;
    nx_tail   = 1'b0;
    k_ld      = 1'b0;
    rsc_clr   = 1'b0;
    rsc1_step = 1'b0;
    rsc2_step = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          k_ld     = 1'b1;
          rsc_clr  = 1'b1;
          cnt_clr  = 1'b1;
          tcnt_clr = 1'b1;
          state_n  = (blk_k == '0) ? TAIL1 : ENC;
        end
      end
      ENC: begin
        if (!fifo_empty && int_valid && adv) begin
          fire      = 1'b1;
          ld_out    = 1'b1;
          nx_xk     = fifo_dout;
          nx_zk1    = rsc1_z;
          nx_zk2    = rsc2_z;
          rsc1_step = 1'b1;
          rsc2_step = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_last) begin
            state_n = TAIL1;
          end
        end
      end
      TAIL1: begin
        if (adv) begin
          ld_out    = 1'b1;
          nx_xk     = rsc1_c;
          nx_zk1    = rsc1_z;
          nx_tail   = 1'b1;
          rsc1_step = 1'b1;
          if (tail_cnt == TAIL_LAST) begin
            tcnt_clr = 1'b1;
            state_n  = TAIL2;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      TAIL2: begin
        // After the third beat, wait here until that beat is taken.
        if (tail_cnt == TAIL_WAIT) begin
          if (adv) begin
            state_n = DONE;
          end
        end else if (adv) begin
          ld_out    = 1'b1;
          nx_xk     = rsc2_c;
          nx_zk2    = rsc2_z;
          nx_tail   = 1'b1;
          rsc2_step = 1'b1;
          tcnt_inc  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Block length capture and bit / tail counters
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      k_q      <= '0;
      bit_cnt  <= '0;
      tail_cnt <= '0;
    end else begin
      if (k_ld) begin
        k_q <= blk_k;
      end
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (cnt_inc) begin
        bit_cnt <= bit_cnt + K_W'(1);
      end
      if (tcnt_clr) begin
        tail_cnt <= '0;
      end else if (tcnt_inc) begin
        tail_cnt <= tail_cnt + 2'd1;
      end
    end
  end

  // Output beat register: payload holds until replaced, valid drops once taken
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ov_q   <= 1'b0;
      xk_q   <= 1'b0;
      zk1_q  <= 1'b0;
      zk2_q  <= 1'b0;
      tail_q <= 1'b0;
    end else if (ld_out) begin
      ov_q   <= 1'b1;
      xk_q   <= nx_xk;
      zk1_q  <= nx_zk1;
      zk2_q  <= nx_zk2;
      tail_q <= nx_tail;
    end else if (out_ready) begin
      ov_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turbo_encoder_core.sv
// tb/tb_turbo_encoder_core.sv - self-checking bench for turbo_encoder_core
`timescale 1ns/1ps
module tb_turbo_encoder_core;

  localparam int K_W        = 13;
  localparam int FIFO_DEPTH = 512;
  localparam int FIFO_AW    = 9;

  logic             clk = 1'b0;
  logic             aclr_n = 1'b0;
  logic             start = 1'b0;
  logic [K_W-1:0]   blk_k = '0;
  logic             sys_valid = 1'b0;
  logic             sys_bit = 1'b0;
  logic             sys_ready;
  logic             int_valid = 1'b0;
  logic             int_bit = 1'b0;
  logic             read_request;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             xk;
  logic             zk1;
  logic             zk2;
  logic             tail;
  logic             busy;
  logic             done;
  logic             fifo_ovf;
  logic [FIFO_AW:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus bits and the expected output beat at the same index.
  typedef struct {
    logic sys_b;
    logic int_b;
    logic xk;
    logic zk1;
    logic zk2;
    logic tail;
  } vec_t;

  vec_t tab_a [14];
  vec_t tab_b [14];
  vec_t tab_z [14];
  vec_t cur   [14];

  turbo_encoder_core #(
    .K_W        (K_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) dut (
    .clk          (clk),
    .aclr_n       (aclr_n),
    .start        (start),
    .blk_k        (blk_k),
    .sys_valid    (sys_valid),
    .sys_bit      (sys_bit),
    .sys_ready    (sys_ready),
    .int_valid    (int_valid),
    .int_bit      (int_bit),
    .read_request (read_request),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .xk           (xk),
    .zk1          (zk1),
    .zk2          (zk2),
    .tail         (tail),
    .busy         (busy),
    .done         (done),
    .fifo_ovf     (fifo_ovf),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [5:0] v);
    vec_t r;
    r.sys_b = v[5];
    r.int_b = v[4];
    r.xk    = v[3];
    r.zk1   = v[2];
    r.zk2   = v[1];
    r.tail  = v[0];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " out_valid"},    int'(out_valid), 0);
    chk({tag, " payload"},      int'({xk, zk1, zk2, tail}), 0);
    chk({tag, " busy"},         int'(busy), 0);
    chk({tag, " done"},         int'(done), 0);
    chk({tag, " fifo_ovf"},     int'(fifo_ovf), 0);
    chk({tag, " read_request"}, int'(read_request), 0);
    chk({tag, " sys_ready"},    int'(sys_ready), 1);
    chk({tag, " fifo_level"},   int'(fifo_level), 0);
  endtask

  // Asynchronous reset pulse, checked while held; leaves the bench at posedge+1.
  task automatic do_reset(input string tag);
    start = 1'b0; sys_valid = 1'b0; int_valid = 1'b0; out_ready = 1'b0;
    #2 aclr_n = 1'b0;
    #1 chk_idle_outputs({tag, " in reset"});
    @(posedge clk); #1 aclr_n = 1'b1;
  endtask

  // Preload k systematic bits, start the block and run it, checking each beat against cur[].
  task automatic run_block(input string tag, input int k, input int stall_at,
                           input int gap_at, input int abort_at);
    int beats = 0;
    int cyc = 0;
    int int_idx = 0;
    int stall_left = 0;
    int gap_left = 0;
    int done_cnt = 0;
    bit stall_used = 0;
    bit gap_used = 0;
    bit acc_prev = 0;
    bit stalled_prev = 0;
    bit finished = 0;
    logic [3:0] held = '0;
    logic [FIFO_AW:0] gap_level = '0;
    for (int i = 0; i < k; i++) begin
      sys_valid = 1'b1;
      sys_bit   = cur[i % 14].sys_b;
      @(posedge clk); #1;
    end
    sys_valid = 1'b0;
    start = 1'b1;
    blk_k = K_W'(k);
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cyc < 400) begin
      if (!stall_used && stall_at >= 0 && beats == stall_at) begin
        stall_left = 5; stall_used = 1;
      end
      if (!gap_used && gap_at >= 0 && int_idx == gap_at) begin
        gap_left = 10; gap_used = 1;
      end
      out_ready = (stall_left == 0);
      int_valid = (gap_left == 0) && (int_idx < k);
      int_bit   = cur[int_idx % 14].int_b;
      @(negedge clk);
      if (stalled_prev) begin
        chk({tag, " stall valid held"},   int'(out_valid), 1);
        chk({tag, " stall payload held"}, int'({xk, zk1, zk2, tail}), int'(held));
      end
      if (stall_left > 0 && out_valid) begin
        chk({tag, " stall read_request"}, int'(read_request), 0);
      end
      if (gap_left > 0) begin
        chk({tag, " gap read_request"}, int'(read_request), 0);
        if (gap_left == 10) gap_level = fifo_level;
        else chk({tag, " gap fifo_level"}, int'(fifo_level), int'(gap_level));
      end
      if (done) begin
        done_cnt++;
        chk({tag, " done beats"}, beats, k + 6);
        chk({tag, " done follows last accept"}, int'(acc_prev), 1);
        finished = 1;
      end
      acc_prev = 0;
      if (out_valid && out_ready) begin
        if (beats < 14)
          chk($sformatf("%s beat %0d", tag, beats), int'({xk, zk1, zk2, tail}),
              int'({cur[beats].xk, cur[beats].zk1, cur[beats].zk2, cur[beats].tail}));
        beats++;
        acc_prev = 1;
      end
      stalled_prev = out_valid && !out_ready;
      held = {xk, zk1, zk2, tail};
      if (read_request) int_idx++;
      if (stall_left > 0) stall_left--;
      if (gap_left > 0) gap_left--;
      if (abort_at >= 0 && beats == abort_at) finished = 1;
      @(posedge clk); #1;
      cyc++;
    end
    int_valid = 1'b0;
    chk({tag, " completed in budget"}, int'(finished), 1);
    if (abort_at < 0) begin
      chk({tag, " beat count"}, beats, k + 6);
      chk({tag, " done pulses"}, done_cnt, 1);
      chk({tag, " busy after"}, int'(busy), 0);
      chk({tag, " rsc1 state"}, int'(dut.u_rsc1.s), 0);
      chk({tag, " rsc2 state"}, int'(dut.u_rsc2.s), 0);
      chk({tag, " fifo drained"}, int'(fifo_level), 0);
    end
  endtask

  initial begin
    bit seen;
    // Impulse on both inputs: (sys,int,xk,zk1,zk2,tail)
    tab_a[0]  = mk(6'b11_1110); tab_a[1]  = mk(6'b00_0110);
    tab_a[2]  = mk(6'b00_0110); tab_a[3]  = mk(6'b00_0110);
    tab_a[4]  = mk(6'b00_0000); tab_a[5]  = mk(6'b00_0000);
    tab_a[6]  = mk(6'b00_0110); tab_a[7]  = mk(6'b00_0000);
    tab_a[8]  = mk(6'b00_0101); tab_a[9]  = mk(6'b00_1001);
    tab_a[10] = mk(6'b00_1101); tab_a[11] = mk(6'b00_0011);
    tab_a[12] = mk(6'b00_1001); tab_a[13] = mk(6'b00_1011);
    // sys = 1,0,1,1,0,0,1,0 ; int = 0,1,1,0,1,0,0,1
    tab_b[0]  = mk(6'b10_1100); tab_b[1]  = mk(6'b01_0110);
    tab_b[2]  = mk(6'b11_1000); tab_b[3]  = mk(6'b10_1100);
    tab_b[4]  = mk(6'b01_0010); tab_b[5]  = mk(6'b00_0000);
    tab_b[6]  = mk(6'b10_1110); tab_b[7]  = mk(6'b01_0110);
    tab_b[8]  = mk(6'b00_1001); tab_b[9]  = mk(6'b00_1101);
    tab_b[10] = mk(6'b00_0001); tab_b[11] = mk(6'b00_0001);
    tab_b[12] = mk(6'b00_0001); tab_b[13] = mk(6'b00_0001);
    // K = 0: six all-zero tail beats from a cleared trellis
    for (int i = 0; i < 14; i++) tab_z[i] = mk((i < 6) ? 6'b00_0001 : 6'b00_0000);

    #3 chk_idle_outputs("power-on reset");
    @(posedge clk); #1 aclr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("idle after reset");

    cur = tab_a; run_block("impulse", 8, -1, -1, -1);
    cur = tab_a; run_block("stall", 8, 3, -1, -1);
    cur = tab_b; run_block("mixed", 8, -1, -1, -1);
    cur = tab_a; run_block("int gap", 8, -1, 3, -1);
    cur = tab_z; run_block("k zero", 0, -1, -1, -1);

    cur = tab_a; run_block("abort", 40, -1, -1, 4);
    do_reset("abort");
    chk("abort busy after reset", int'(busy), 0);
    cur = tab_a; run_block("after abort", 8, -1, -1, -1);

    // Overflow: push FIFO_DEPTH+2 bits without starting a block
    sys_valid = 1'b1;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      sys_bit = i[0];
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ovf fifo_level", int'(fifo_level), FIFO_DEPTH);
    chk("ovf sys_ready", int'(sys_ready), 0);
    chk("ovf flag", int'(fifo_ovf), 1);

    // Full FIFO with a pop: the push held on sys_valid must not enter that cycle
    @(posedge clk); #1;
    start = 1'b1; blk_k = K_W'(1); int_valid = 1'b1; int_bit = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (read_request) begin
        seen = 1;
        chk("full pop level before", int'(fifo_level), FIFO_DEPTH);
        chk("full pop sys_ready", int'(sys_ready), 0);
      end
    end
    chk("full pop fire seen", int'(seen), 1);
    @(negedge clk);
    chk("full pop level after", int'(fifo_level), FIFO_DEPTH - 1);
    @(posedge clk); #1;
    sys_valid = 1'b0;
    do_reset("mid-block");
    chk("ovf cleared by reset", int'(fifo_ovf), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
